// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC sequencer merging sequential fetch, D-stage redirects, stalls and halt
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int unsigned CODE_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        j_sel,
   input  logic [31:0] j_target,
   input  logic        jr_sel,
   input  logic [31:0] jr_target,
   output logic [31:0] npc,
   output logic        pc_we,
   output logic        ifid_we,
   output logic        ifid_clr,
   output logic        halted,
   output logic        err,
   output logic [31:0] fetch_cnt
);
   typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;
   localparam logic [32:0] LIMIT = {1'b0, RESET_PC} + 33'(CODE_WORDS) * 33'd4;
   state_t      state_q, state_d;
   logic [31:0] pend_q, pend_d, cnt_q, cnt_d, tgt, cand;
   logic        err_q, err_d, redir, use_seq, cand_ok, live, go;
   logic [32:0] seq;
   // candidate next PC and its legality; a carry out of pc+4 marks a wrapped, illegal address
   always_comb begin
      redir   = jr_sel | j_sel | br_taken;
      tgt     = jr_sel ? jr_target : j_sel ? j_target : br_target;
      use_seq = !redir && state_q != HOLD;
      seq     = {1'b0, pc} + 33'd4;
      cand    = redir ? tgt : state_q == HOLD ? pend_q : seq[31:0];
      cand_ok = cand[1:0] == 2'b00 && cand >= RESET_PC && {1'b0, cand} < LIMIT && !(use_seq && seq[32]);
      live    = !reset && state_q != HALT;
      go      = live && !stall;
   end
   // next-state: latch redirects under stall, advance or halt when free
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (live && stall && redir) begin
         state_d = HOLD;
         pend_d  = tgt;
      end else if (go && cand_ok) begin
         state_d = RUN;
         cnt_d   = cnt_q + 32'd1;
      end else if (go) begin
         state_d = HALT;
         err_d   = !use_seq;
      end
   end
   // outputs: reset and halt both hold the PC and flush IF/ID; stall freezes F and D
   always_comb begin
      npc      = reset ? RESET_PC : go && cand_ok ? cand : pc;
      pc_we    = go && cand_ok;
      ifid_we  = !(live && stall);
      ifid_clr = !(live && (stall || cand_ok));
   end
   // state register with synchronous reset; a pending redirect is dropped on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         pend_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end
   assign halted    = state_q == HALT;
   assign err       = err_q;
   assign fetch_cnt = cnt_q;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC sequencer for the fetch stage of the five-stage MIPS pipeline. Each cycle it computes the next PC and PC write-enable for the PC/instruction-ROM fetch unit, and the enable/clear for the IF/ID register. It merges sequential fetch, D-stage branch/jump redirects and the hazard unit's stall, and holds a redirect that arrives during a stall. It halts fetch cleanly on running off the code window or on an illegal redirect target.

## Interface
- RESET_PC, 32'h00003000, PC value after reset; base of the code window
- CODE_WORDS, 1024, size of the instruction ROM in words; window is [RESET_PC, RESET_PC + 4*CODE_WORDS)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- pc  in  32  current PC from the fetch unit
- stall  in  1  hazard unit freeze request for F and D
- br_taken  in  1  D-stage branch resolved taken
- br_target  in  32  branch target
- j_sel  in  1  D-stage j/jal
- j_target  in  32  j/jal target
- jr_sel  in  1  D-stage jr/jalr
- jr_target  in  32  register target
- npc  out  32  next PC to the fetch unit
- pc_we  out  1  PC write-enable to the fetch unit
- ifid_we  out  1  IF/ID register enable
- ifid_clr  out  1  IF/ID register clear (insert bubble)
- halted  out  1  fetch stopped
- err  out  1  halt was caused by an illegal target
- fetch_cnt  out  32  number of instructions accepted into IF/ID since reset

## Operation
- States: RUN, HOLD (redirect pending), HALT. Registers: state, pend_target[31:0], err, fetch_cnt.
- Redirect select: jr_sel > j_sel > br_taken. redir = any of the three. tgt = the selected target.
- Legal address a: a[1:0]==0 and RESET_PC <= a < RESET_PC + 4*CODE_WORDS, compared unsigned at 32 bits. pc+4 wraps modulo 2^32; a wrapped value is illegal.
- Candidate next PC cand in RUN or HOLD with stall=0, in this order:
  - tgt if redir.
  - Otherwise pend_target if in HOLD.
  - Otherwise pc+4.
- RUN or HOLD, stall=0, cand legal:
  - npc=cand, pc_we=1, ifid_we=1, ifid_clr=0.
  - fetch_cnt += 1.
  - Next state RUN.
- RUN or HOLD, stall=0, cand illegal:
  - pc_we=0, ifid_we=1, ifid_clr=1.
  - Next state HALT.
  - err<=1 if cand came from a redirect or pending target; err<=0 if it came from sequential pc+4 (normal end of code).
- RUN or HOLD, stall=1:
  - npc=pc, pc_we=0, ifid_we=0, ifid_clr=0; fetch_cnt holds.
  - If redir: pend_target<=tgt, next state HOLD. A new redirect overwrites an older pending one.
  - Otherwise the state is unchanged.
  - Legality is checked only when the target is applied, never when latched.
- HALT:
  - npc=pc, pc_we=0, ifid_we=1, ifid_clr=1 every cycle; all inputs ignored.
  - Exit only by reset.
- Delay slot: the instruction in F when a redirect is seen is the delay slot and is never cleared. The redirect target becomes the PC after it.
- halted = (state==HALT).
- fetch_cnt wraps modulo 2^32.

## Timing
- npc, pc_we, ifid_we and ifid_clr are combinational from the inputs and current state, valid in the same cycle. State, pend_target, err and fetch_cnt update at posedge.
- Redirect latency: a redirect seen with stall=0 in cycle n gives PC=tgt after edge n.
- A redirect latched during a stall is applied in the first cycle with stall=0, unless a fresh redirect in that cycle overrides it.
- While reset=1 (overrides everything):
  - npc=RESET_PC, pc_we=0, ifid_we=1, ifid_clr=1.
  - At the edge: state<=RUN, pend_target<=0, err<=0, fetch_cnt<=0.
- After reset: halted=0 and err=0.
- Reset mid-stall or mid-HOLD discards the pending redirect.
- Reset in HALT returns to RUN.

## Test plan
- Sequential fetch: reset, then 4 cycles idle starting from pc=0x3000 -> npc 0x3004, 0x3008, 0x300C, 0x3010; pc_we=1 each cycle; fetch_cnt=4.
- Redirect priority: jr_sel=1 (0x3100), j_sel=1 (0x3200) and br_taken=1 (0x3300) in the same cycle, stall=0 -> npc=0x3100, pc_we=1.
- Redirect during stall:
  - Stall 3 cycles with br_taken=1 (0x3040) in the first stall cycle only -> pc_we=0 throughout, state HOLD.
  - On release -> npc=0x3040; fetch_cnt unchanged during the stall.
  - Repeat with j_sel=1 (0x3080) on the release cycle -> npc=0x3080.
- Illegal target: br_target=0x3002, then separately 0x2FFC -> pc_we=0, halted=1 and err=1 after the edge, ifid_clr=1 held; further redirects ignored.
- End of code: pc=0x3FFC (CODE_WORDS=1024), idle -> halted=1, err=0, pc_we=0; then reset=1 for one cycle -> halted=0, fetch_cnt=0, npc=0x3004 next cycle.
- Reset mid-HOLD: latch a pending target 0x3200, assert reset, then release stall -> npc=0x3004, and the pending target is never applied.
